// File: rtl/prescaler_sched.sv
// rtl/prescaler_sched.sv - shadow/active divider scheduler with atomic commit for the multi-channel prescaler
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   wr_en        shadow divider write strobe
//   wr_sel       channel index for the write
//   wr_data      divider value to write (0 is rejected)
//   commit       apply pending shadow values at the next boundary
//   force_commit apply shadow values immediately, skipping the boundary wait
//   boundary     one-cycle safe-update pulse from the datapath
//   div          active dividers, channel i at [BITS*(i+1)-1 : BITS*i]
//   div_valid    high once the first load has happened
//   restart      one-cycle pulse coincident with a div update
//   busy         high while waiting for or performing a load
//   pending      per-channel: shadow written since the last load
//   err_zero     one-cycle pulse on a rejected zero write
//   commit_drop  one-cycle pulse when commit/force_commit arrives while busy
//   timed_out    one-cycle pulse (with restart) when the load came from the timeout

module prescaler_sched #(
    parameter int SIZE    = 4,
    parameter int BITS    = 32,
    parameter int TIMEOUT = 1024,
    localparam int SEL_W  = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [BITS-1:0]      wr_data,
    input  logic                 commit,
    input  logic                 force_commit,
    input  logic                 boundary,
    output logic [BITS*SIZE-1:0] div,
    output logic                 div_valid,
    output logic                 restart,
    output logic                 busy,
    output logic [SIZE-1:0]      pending,
    output logic                 err_zero,
    output logic                 commit_drop,
    output logic                 timed_out
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 timeout_hit;
    logic                 load_timed_q;
    logic [BITS-1:0]      shadow [SIZE];
    logic [SIZE-1:0]      pending_d;
    logic                 wr_ok;
    logic                 wr_good;

    // Out-of-range selects are silently dropped; only in-range writes can raise err_zero.
    assign wr_ok   = wr_en && ({1'b0, wr_sel} < (SEL_W+1)'(SIZE));
    assign wr_good = wr_ok && (wr_data != '0);

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (force_commit) begin
                    state_d = LOAD;
                end else if (commit && (pending != '0)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A boundary in the same cycle as the timeout wins, so the load is not flagged.
                if (boundary) begin
                    state_d = LOAD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = LOAD;
                    timeout_hit = 1'b1;
                end
            end
            LOAD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The load clears pending first; a write on the same edge re-arms its bit.
    always_comb begin
        pending_d = (state_q == LOAD) ? '0 : pending;
        if (wr_good) begin
            pending_d[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            load_timed_q <= 1'b0;
            busy         <= 1'b0;
            div_valid    <= 1'b0;
            restart      <= 1'b0;
            timed_out    <= 1'b0;
            err_zero     <= 1'b0;
            commit_drop  <= 1'b0;
            pending      <= '0;
            for (int i = 0; i < SIZE; i++) begin
                shadow[i]              <= BITS'(1);
                div[i*BITS +: BITS]    <= BITS'(1);
            end
        end else begin
            state_q      <= state_d;
            busy         <= (state_d != IDLE);
            cnt_q        <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            load_timed_q <= timeout_hit;
            restart      <= (state_q == LOAD);
            timed_out    <= (state_q == LOAD) && load_timed_q;
            err_zero     <= wr_ok && (wr_data == '0);
            commit_drop  <= (commit || force_commit) && (state_q != IDLE);
            pending      <= pending_d;

            // Active takes the shadow contents from before this edge, so a same-edge write stays pending.
            if (state_q == LOAD) begin
                div_valid <= 1'b1;
                for (int i = 0; i < SIZE; i++) begin
                    div[i*BITS +: BITS] <= shadow[i];
                end
            end

            if (wr_good) begin
                shadow[wr_sel] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_prescaler_sched.sv
// tb/tb_prescaler_sched.sv - scoreboard bench for prescaler_sched with directed and random stimulus

module tb_prescaler_sched;

    localparam int SIZE = 4;
    localparam int BITS = 32;
    localparam int TO   = 16;
    localparam int SW   = 2;

    logic                 clk;
    logic                 rst;
    logic                 wr_en;
    logic [SW-1:0]        wr_sel;
    logic [BITS-1:0]      wr_data;
    logic                 commit;
    logic                 force_commit;
    logic                 boundary;
    logic [BITS*SIZE-1:0] div;
    logic                 div_valid;
    logic                 restart;
    logic                 busy;
    logic [SIZE-1:0]      pending;
    logic                 err_zero;
    logic                 commit_drop;
    logic                 timed_out;

    prescaler_sched #(.SIZE(SIZE), .BITS(BITS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit(commit), .force_commit(force_commit), .boundary(boundary),
        .div(div), .div_valid(div_valid), .restart(restart), .busy(busy),
        .pending(pending), .err_zero(err_zero), .commit_drop(commit_drop),
        .timed_out(timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [BITS*SIZE-1:0] d;
        logic                 t;
    } load_t;
    load_t exp_q[$];

    // Reference model: phase 0 idle, 1 waiting for boundary, 2 loading.
    logic [BITS-1:0] m_shadow [SIZE];
    logic [BITS-1:0] m_active [SIZE];
    logic [SIZE-1:0] m_pend;
    logic            m_valid, m_ez, m_drop, m_timed;
    int              m_ph, m_deadline, cyc;

    function automatic logic [BITS*SIZE-1:0] pack_active();
        logic [BITS*SIZE-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*BITS +: BITS] = m_active[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) begin
            m_shadow[i] = 1;
            m_active[i] = 1;
        end
        m_pend = '0; m_valid = 0; m_ez = 0; m_drop = 0; m_timed = 0;
        m_ph = 0; m_deadline = 0;
        exp_q.delete();
    endtask

    task automatic chk(input string name, input logic [BITS*SIZE-1:0] act, input logic [BITS*SIZE-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic check_outputs();
        chk("div", div, pack_active());
        chk("div_valid", {127'd0, div_valid}, {127'd0, m_valid});
        chk("busy", {127'd0, busy}, {127'd0, (m_ph != 0)});
        chk("pending", {124'd0, pending}, {124'd0, m_pend});
        chk("err_zero", {127'd0, err_zero}, {127'd0, m_ez});
        chk("commit_drop", {127'd0, commit_drop}, {127'd0, m_drop});
    endtask

    task automatic step(input logic we, input int sel, input logic [BITS-1:0] data,
                        input logic cm, input logic fc, input logic bd);
        int  ph_n;
        logic ok;
        load_t e;
        wr_en = we; wr_sel = SW'(sel); wr_data = data;
        commit = cm; force_commit = fc; boundary = bd;

        ok     = we && (sel < SIZE);
        m_ez   = ok && (data == 0);
        m_drop = (cm || fc) && (m_ph != 0);
        ph_n   = m_ph;
        if (m_ph == 2) begin
            for (int i = 0; i < SIZE; i++) m_active[i] = m_shadow[i];
            m_pend  = '0;
            m_valid = 1;
            e.d = pack_active();
            e.t = m_timed;
            exp_q.push_back(e);
            ph_n = 0;
        end else if (m_ph == 0) begin
            if (fc) begin
                ph_n = 2; m_timed = 0;
            end else if (cm && m_pend != 0) begin
                ph_n = 1; m_deadline = cyc + TO;
            end
        end else begin
            if (bd) begin
                ph_n = 2; m_timed = 0;
            end else if (cyc == m_deadline) begin
                ph_n = 2; m_timed = 1;
            end
        end
        if (ok && data != 0) begin
            m_shadow[sel] = data;
            m_pend[sel]   = 1'b1;
        end
        m_ph = ph_n;
        cyc++;

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int sel, input logic [BITS-1:0] data);
        step(1, sel, data, 0, 0, 0);
    endtask

    // Scoreboard monitor: every restart/timed_out cycle consumes one predicted load.
    always @(negedge clk) begin
        if (!rst && (restart || timed_out)) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_load cyc=%0d restart=%0b timed_out=%0b required none", cyc, restart, timed_out);
            end else begin
                load_t e;
                e = exp_q.pop_front();
                if (restart !== 1'b1 || div !== e.d || timed_out !== e.t) begin
                    fails++;
                    $display("FAIL load cyc=%0d restart=%0b div=%0h timed_out=%0b required restart=1 div=%0h timed_out=%0b",
                             cyc, restart, div, timed_out, e.d, e.t);
                end
            end
        end
    end

    task automatic check_reset_now(input string tag);
        chk({tag, "_div"}, div, {32'd1, 32'd1, 32'd1, 32'd1});
        chk({tag, "_flags"}, {121'd0, div_valid, restart, busy, err_zero, commit_drop, timed_out, 1'b0},
            128'd0);
        chk({tag, "_pending"}, {124'd0, pending}, 128'd0);
    endtask

    initial begin
        wr_en = 0; wr_sel = 0; wr_data = 0; commit = 0; force_commit = 0; boundary = 0;
        cyc = 0;
        rst = 1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_now("reset");
        rst = 0;

        // Two writes, then commit with a boundary five cycles later.
        wr(0, 10);
        wr(2, 7);
        chk("plan_pending", {124'd0, pending}, {124'd0, 4'b0101});
        step(0, 0, 0, 1, 0, 0);
        idle(4);
        step(0, 0, 0, 0, 0, 1);
        idle(3);
        chk("plan_div", div, {32'd1, 32'd7, 32'd1, 32'd10});

        // Commit with no boundary: timeout load.
        wr(1, 20);
        step(0, 0, 0, 1, 0, 0);
        idle(TO + 4);

        // Boundary on the exact timeout cycle.
        wr(3, 4);
        step(0, 0, 0, 1, 0, 0);
        idle(TO - 1);
        step(0, 0, 0, 0, 0, 1);
        idle(3);

        // Zero write rejected, then a commit with nothing pending.
        step(1, 1, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 0);
        idle(3);

        // Force, then a commit during the LOAD cycle is dropped.
        wr(3, 3);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        chk("plan_force_ch3", {96'd0, div[127:96]}, 128'd3);

        // Write in the LOAD cycle stays pending.
        wr(0, 11);
        step(0, 0, 0, 1, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1);
        wr(1, 5);
        idle(2);
        chk("plan_load_write", {124'd0, pending}, {124'd0, 4'b0010});

        // Asynchronous reset in the middle of WAIT.
        wr(2, 9);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        #2;
        rst = 1;
        #1;
        check_reset_now("midwait_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic we, cm, fc, bd;
            int sel;
            logic [BITS-1:0] data;
            we   = ($urandom % 4) == 0;
            sel  = $urandom % SIZE;
            data = (($urandom % 8) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            cm   = ($urandom % 8) == 0;
            fc   = ($urandom % 32) == 0;
            bd   = ($urandom % 6) == 0;
            step(we, sel, data, cm, fc, bd);
        end
        idle(TO + 5);
        chk("drain_queue", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
